// File: rtl/eth_poly_readout.sv
// eth_poly_readout: sweeps one processor coefficient memory over the Ethernet access port and streams the words out.
// Optional feature: define READOUT_CHECKSUM_EN for a running XOR of streamed words on checksum.
// Ports: clk, rst (async, active-high); start/proc_sel/mem_sel request; busy/done status;
//   interrupt_eth/instruction_eth/operand_eth/address_eth/doutb_eth memory port;
//   m_data/m_valid/m_ready/m_last output stream; checksum.
module eth_poly_readout #(
  parameter int DATA_W = 60,
  parameter int ADDR_W = 11,
  parameter int DEPTH = 2048,
  parameter int RD_LAT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] INSTR_RD = 8'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        proc_sel,
  input  logic [3:0]        mem_sel,
  output logic              busy,
  output logic              done,
  output logic              interrupt_eth,
  output logic [7:0]        instruction_eth,
  output logic [7:0]        operand_eth,
  output logic [ADDR_W-1:0] address_eth,
  input  logic [DATA_W-1:0] doutb_eth,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] checksum
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [2:0] p_q;
  logic [3:0] m_q;
  logic [ADDR_W-1:0] addr, out_cnt;
  logic [RD_LAT-1:0] pipe;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [CW-1:0] used;
  logic accept, owning, issue, push, pop, last_addr;
  // Reads already in flight reserve a FIFO slot, so a push can never hit a full FIFO.
  assign used = CW'(count) + CW'($countones(pipe));
  assign accept = start && state == IDLE;
  assign owning = state == SETUP || state == ISSUE || state == DRAIN;
  assign last_addr = addr == ADDR_W'(DEPTH - 1);
  assign issue = state == ISSUE && used < CW'(FIFO_DEPTH);
  assign push = pipe[RD_LAT-1];
  assign m_valid = count != 0;
  assign pop = m_valid && m_ready;
  assign busy = owning;
  assign done = state == DONE;
  assign interrupt_eth = owning;
  assign instruction_eth = owning ? INSTR_RD : 8'd0;
  assign operand_eth = owning ? {p_q, 5'd0} + 8'(m_q) : 8'd0;
  assign address_eth = addr;
  assign m_data = m_valid ? mem[rd_ptr] : '0;
  assign m_last = m_valid && out_cnt == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? SETUP : IDLE;
      SETUP: state_n = ISSUE;
      ISSUE: state_n = issue && last_addr ? DRAIN : ISSUE;
      // Leave as soon as the final word is being popped so done lands right after it.
      DRAIN: state_n = pipe == '0 && (count == 0 || (count == 1 && pop)) ? DONE : DRAIN;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p_q <= '0;
      m_q <= '0;
      addr <= '0;
      out_cnt <= '0;
      pipe <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      pipe <= RD_LAT'({pipe, issue});
      if (accept) begin
        p_q <= proc_sel;
        m_q <= mem_sel;
        addr <= '0;
        out_cnt <= '0;
      end else begin
        if (issue && !last_addr) addr <= addr + 1'b1;
        if (pop) out_cnt <= out_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= doutb_eth;
  end
`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum <= '0;
    else if (accept) csum <= '0;
    else if (pop) csum <= csum ^ m_data;
  end
  assign checksum = csum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_eth_poly_readout.sv
// tb_eth_poly_readout: table-driven sweeps with random back-pressure against a formula memory model.
module tb_eth_poly_readout;
  logic clk = 1'b0;
  logic rst, start, m_ready;
  logic [2:0] proc_sel;
  logic [3:0] mem_sel;
  logic busy, done, interrupt_eth, m_valid, m_last;
  logic [7:0] instruction_eth, operand_eth;
  logic [10:0] address_eth;
  logic [59:0] doutb_eth, m_data, checksum;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  eth_poly_readout dut (
    .clk(clk), .rst(rst), .start(start), .proc_sel(proc_sel), .mem_sel(mem_sel),
    .busy(busy), .done(done), .interrupt_eth(interrupt_eth), .instruction_eth(instruction_eth),
    .operand_eth(operand_eth), .address_eth(address_eth), .doutb_eth(doutb_eth),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .checksum(checksum)
  );
  function automatic logic [59:0] word(input logic [2:0] p, input int i);
    logic [29:0] v;
    v = 30'(i + 2048 * int'(p));
    return {v * 30'd2 + 30'd1, v * 30'd2};
  endfunction
  logic [10:0] a_q;
  always @(posedge clk) begin
    a_q <= address_eth;
    doutb_eth <= word(operand_eth[7:5], int'(a_q));
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  typedef struct {
    logic [2:0] p;
    logic [3:0] m;
    int ready_pct;
    int ready_every;
    int stall0;
    int restart_at;
    int abort_at;
    logic [7:0] exp_op;
    logic [59:0] exp_first;
    int exp_cycles;
  } vec_t;
  vec_t vecs[7];
  task automatic run_row(input vec_t v);
    int cyc, idx, own;
    bit got_done;
    logic [59:0] xe, first;
    logic [7:0] op_seen;
    proc_sel = v.p;
    mem_sel = v.m;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    idx = 0;
    own = 0;
    got_done = 0;
    xe = '0;
    first = '0;
    op_seen = v.exp_op;
    while (cyc < 20000) begin
      if (v.restart_at > 0 && cyc == v.restart_at) begin
        start = 1'b1;
        proc_sel = 3'd3;
      end else begin
        start = 1'b0;
        proc_sel = v.p;
      end
      if (cyc <= v.stall0) m_ready = 1'b0;
      else if (v.ready_every > 0) m_ready = (cyc % v.ready_every) == 0;
      else m_ready = $urandom_range(99) < v.ready_pct;
      #1;
      if (v.stall0 > 0 && cyc == v.stall0) begin
        chk("stall_addr", 64'(address_eth), 64'd4);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_head", 64'(m_data), 64'(word(v.p, 0)));
      end
      if (interrupt_eth) begin
        own++;
        if (operand_eth !== v.exp_op) op_seen = operand_eth;
      end
      if (m_valid && m_ready) begin
        chk("data", 64'(m_data), 64'(word(v.p, idx)));
        chk("last", 64'(m_last), 64'(idx == 2047));
        if (idx == 0) first = m_data;
        if (idx == 5 && v.p == 3'd0) chk("word5", 64'(m_data), 64'({30'd11, 30'd10}));
        xe ^= word(v.p, idx);
        idx++;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (v.abort_at >= 0 && idx == v.abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_intr", 64'(interrupt_eth), 64'd0);
        chk("abort_op", 64'(operand_eth), 64'd0);
        chk("abort_instr", 64'(instruction_eth), 64'd0);
        chk("abort_addr", 64'(address_eth), 64'd0);
        chk("abort_valid", 64'(m_valid), 64'd0);
        chk("abort_first", 64'(first), 64'(v.exp_first));
        rst = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", 64'(got_done), 64'd1);
    if (v.exp_cycles > 0) chk("done_cycle", 64'(cyc), 64'(v.exp_cycles));
    chk("words", 64'(idx), 64'd2048);
    chk("first", 64'(first), 64'(v.exp_first));
    chk("operand", 64'(op_seen), 64'(v.exp_op));
    chk("owned", 64'(own > 2048), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
`ifdef READOUT_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(xe));
`else
    chk("checksum", 64'(checksum), 64'd0);
`endif
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("released", 64'({interrupt_eth, instruction_eth, operand_eth}), 64'd0);
  endtask
  initial begin
    vecs[0] = '{3'd0, 4'd4, 100, 0, 0, 0, -1, 8'd4, {30'd1, 30'd0}, 2053};
    vecs[1] = '{3'd5, 4'd4, 0, 3, 0, 0, -1, 8'd164, {30'd20481, 30'd20480}, 0};
    vecs[2] = '{3'd2, 4'd4, 100, 0, 100, 0, -1, 8'd68, {30'd8193, 30'd8192}, 0};
    vecs[3] = '{3'd0, 4'd4, 70, 0, 0, 50, -1, 8'd4, {30'd1, 30'd0}, 0};
    vecs[4] = '{3'd0, 4'd4, 100, 0, 0, 0, 1000, 8'd4, {30'd1, 30'd0}, 0};
    vecs[5] = '{3'd1, 4'd4, 100, 0, 0, 0, -1, 8'd36, {30'd4097, 30'd4096}, 2053};
    vecs[6] = '{3'd3, 4'd4, 50, 0, 0, 0, -1, 8'd100, {30'd12289, 30'd12288}, 0};
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    proc_sel = '0;
    mem_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_intr", 64'(interrupt_eth), 64'd0);
    chk("rst_instr", 64'(instruction_eth), 64'd0);
    chk("rst_op", 64'(operand_eth), 64'd0);
    chk("rst_addr", 64'(address_eth), 64'd0);
    chk("rst_stream", 64'({m_valid, m_last}), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run_row(vecs[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
